// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard/forwarding unit: EX forwarding-mux selects
// and the stall FSM state type.
package hazard_forward_unit_pkg;

    localparam logic [1:0] FWD_REG = 2'd0;  // ID/EX register-file value
    localparam logic [1:0] FWD_WB  = 2'd1;  // MEM/WB result
    localparam logic [1:0] FWD_MEM = 2'd2;  // EX/MEM ALU result

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage side bundle of the hazard/forwarding unit plus its pipeline-control
// outputs and debug view of the FSM and shadow slots.
interface hazard_forward_unit_if #(
    parameter int REG_AW = 5
) ();
    import hazard_forward_unit_pkg::*;

    // No valid/ready pair: the ID fields are taken as a new instruction on every
    // cycle where hold=0; the control outputs are level signals valid each cycle.
    logic [REG_AW-1:0]       id_rs;
    logic [REG_AW-1:0]       id_rt;
    logic                    id_use_rs;
    logic                    id_use_rt;
    logic [REG_AW-1:0]       id_dst;
    logic                    id_reg_write;
    logic                    id_mem_read;
    logic                    ex_branch_tk;
    logic                    hold;

    logic [1:0]              fwd_a_sel;
    logic [1:0]              fwd_b_sel;
    logic                    pc_we;
    logic                    ifid_we;
    logic                    ifid_flush;
    logic                    idex_bubble;

    state_t                  dbg_state;
    logic [1:0]              dbg_cnt;
    logic [3*(REG_AW+2)-1:0] dbg_slots;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_write,
               id_mem_read, ex_branch_tk, hold,
        input  fwd_a_sel, fwd_b_sel, pc_we, ifid_we, ifid_flush, idex_bubble,
               dbg_state, dbg_cnt, dbg_slots
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_write,
               id_mem_read, ex_branch_tk, hold,
        output fwd_a_sel, fwd_b_sel, pc_we, ifid_we, ifid_flush, idex_bubble,
               dbg_state, dbg_cnt, dbg_slots
    );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Forwarding comparator for one EX operand: the newest matching producer
// (EX slot before MEM slot) decides the select; register $0 never forwards.
module hazard_forward_unit_fwd_select #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_reg_write,
    output logic [1:0]        sel
);
    import hazard_forward_unit_pkg::*;

    always_comb begin
        sel = FWD_REG;
        if (use_src && (src != '0)) begin
            if (ex_reg_write && (src == ex_dst)) begin
                sel = FWD_MEM;
            end else if (mem_reg_write && (src == mem_dst)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control beside the ID stage: shadows EX/MEM/WB
// destination info, registers the EX operand selects, and drives stall/flush.
module hazard_forward_unit #(
    parameter int REG_AW      = 5,
    parameter int LOAD_STALLS = 1
) (
    input logic                  clk,
    input logic                  rst,
    hazard_forward_unit_if.slave bus
);
    import hazard_forward_unit_pkg::*;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic              reg_write;
        logic              mem_read;
    } slot_t;

    localparam logic [1:0] STALL_INIT  = 2'(LOAD_STALLS - 1);
    localparam logic       MULTI_STALL = (LOAD_STALLS > 1);

    slot_t      id_slot;
    slot_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] fwd_a_sel_q, fwd_a_sel_d;
    logic [1:0] fwd_b_sel_q, fwd_b_sel_d;
    logic [1:0] sel_a, sel_b;
    logic       hazard;
    logic       pc_we, ifid_we, ifid_flush, idex_bubble;

    assign id_slot = {bus.id_dst, bus.id_reg_write, bus.id_mem_read};

    // Load in EX whose destination the ID instruction actually reads.
    always_comb begin
        hazard = ex_q.mem_read && (ex_q.dst != '0) &&
                 ((bus.id_use_rs && (bus.id_rs == ex_q.dst)) ||
                  (bus.id_use_rt && (bus.id_rt == ex_q.dst)));
    end

    hazard_forward_unit_fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src          (bus.id_rs),
        .use_src      (bus.id_use_rs),
        .ex_dst       (ex_q.dst),
        .ex_reg_write (ex_q.reg_write),
        .mem_dst      (mem_q.dst),
        .mem_reg_write(mem_q.reg_write),
        .sel          (sel_a)
    );

    hazard_forward_unit_fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src          (bus.id_rt),
        .use_src      (bus.id_use_rt),
        .ex_dst       (ex_q.dst),
        .ex_reg_write (ex_q.reg_write),
        .mem_dst      (mem_q.dst),
        .mem_reg_write(mem_q.reg_write),
        .sel          (sel_b)
    );

    // Priority: hold freezes everything, then a taken branch, then load-use stall.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (bus.hold) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (bus.ex_branch_tk) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                        cnt_d       = STALL_INIT;
                        if (MULTI_STALL) begin
                            state_d = ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_d       = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        fwd_a_sel_d = fwd_a_sel_q;
        fwd_b_sel_d = fwd_b_sel_q;
        if (!bus.hold) begin
            ex_d        = idex_bubble ? '0 : id_slot;
            mem_d       = ex_q;
            wb_d        = mem_q;
            fwd_a_sel_d = idex_bubble ? FWD_REG : sel_a;
            fwd_b_sel_d = idex_bubble ? FWD_REG : sel_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            fwd_a_sel_q <= FWD_REG;
            fwd_b_sel_q <= FWD_REG;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
        end
    end

    assign bus.fwd_a_sel   = fwd_a_sel_q;
    assign bus.fwd_b_sel   = fwd_b_sel_q;
    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_cnt     = cnt_q;
    assign bus.dbg_slots   = {ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (LOAD_STALLS=1 and 3) share one
// ID stimulus stream; directed scenarios plus random traffic against a model.
module tb_hazard_forward_unit;
    import hazard_forward_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.REG_AW(5)) if1 ();
    hazard_forward_unit_if #(.REG_AW(5)) if3 ();

    hazard_forward_unit #(.REG_AW(5), .LOAD_STALLS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    hazard_forward_unit #(.REG_AW(5), .LOAD_STALLS(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    assign if3.id_rs        = if1.id_rs;
    assign if3.id_rt        = if1.id_rt;
    assign if3.id_use_rs    = if1.id_use_rs;
    assign if3.id_use_rt    = if1.id_use_rt;
    assign if3.id_dst       = if1.id_dst;
    assign if3.id_reg_write = if1.id_reg_write;
    assign if3.id_mem_read  = if1.id_mem_read;
    assign if3.ex_branch_tk = if1.ex_branch_tk;
    assign if3.hold         = if1.hold;

    // Observed outputs, index 0 = LOAD_STALLS=1, index 1 = LOAD_STALLS=3
    logic [1:0] o_a[2], o_b[2], o_cnt[2];
    logic       o_pc[2], o_ifwe[2], o_fl[2], o_bub[2];
    state_t     o_st[2];
    assign o_a[0] = if1.fwd_a_sel;    assign o_a[1] = if3.fwd_a_sel;
    assign o_b[0] = if1.fwd_b_sel;    assign o_b[1] = if3.fwd_b_sel;
    assign o_pc[0] = if1.pc_we;       assign o_pc[1] = if3.pc_we;
    assign o_ifwe[0] = if1.ifid_we;   assign o_ifwe[1] = if3.ifid_we;
    assign o_fl[0] = if1.ifid_flush;  assign o_fl[1] = if3.ifid_flush;
    assign o_bub[0] = if1.idex_bubble; assign o_bub[1] = if3.idex_bubble;
    assign o_st[0] = if1.dbg_state;   assign o_st[1] = if3.dbg_state;
    assign o_cnt[0] = if1.dbg_cnt;    assign o_cnt[1] = if3.dbg_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    // Age-ordered history of what entered EX: age 0 = in EX, 1 = in MEM, 2 = in WB.
    typedef struct { logic [4:0] dst; logic rw; logic mr; } ent_t;
    ent_t       pipe[2][3];
    int         stall_left[2];
    int         n_stalls[2] = '{1, 3};
    logic [1:0] m_a[2], m_b[2];
    logic       m_pc[2], m_ifwe[2], m_fl[2], m_bub[2], m_loaduse[2];

    logic [4:0] in_rs, in_rt, in_dst;
    logic       in_urs, in_urt, in_rw, in_mr, in_br, in_hold;

    function automatic logic [1:0] newest_producer(int k, logic [4:0] src, logic use_it);
        if (!use_it || src == 5'd0) return 2'd0;
        for (int age = 0; age < 2; age++)
            if (pipe[k][age].rw && pipe[k][age].dst == src) return (age == 0) ? 2'd2 : 2'd1;
        return 2'd0;
    endfunction

    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            m_loaduse[k] = pipe[k][0].mr && (pipe[k][0].dst != 5'd0) &&
                           ((in_urs && in_rs == pipe[k][0].dst) || (in_urt && in_rt == pipe[k][0].dst));
            m_pc[k] = 1'b1; m_ifwe[k] = 1'b1; m_fl[k] = 1'b0; m_bub[k] = 1'b0;
            if (in_hold) begin
                m_pc[k] = 1'b0; m_ifwe[k] = 1'b0;
            end else if (in_br) begin
                m_fl[k] = 1'b1; m_bub[k] = 1'b1;
            end else if (stall_left[k] > 0 || m_loaduse[k]) begin
                m_pc[k] = 1'b0; m_ifwe[k] = 1'b0; m_bub[k] = 1'b1;
            end
        end
    endtask

    task automatic model_edge();
        ent_t incoming;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int age = 0; age < 3; age++) pipe[k][age] = '{dst: 5'd0, rw: 1'b0, mr: 1'b0};
                stall_left[k] = 0; m_a[k] = 2'd0; m_b[k] = 2'd0;
            end else if (!in_hold) begin
                m_a[k] = m_bub[k] ? 2'd0 : newest_producer(k, in_rs, in_urs);
                m_b[k] = m_bub[k] ? 2'd0 : newest_producer(k, in_rt, in_urt);
                if (m_bub[k]) incoming = '{dst: 5'd0, rw: 1'b0, mr: 1'b0};
                else          incoming = '{dst: in_dst, rw: in_rw, mr: in_mr};
                pipe[k][2] = pipe[k][1];
                pipe[k][1] = pipe[k][0];
                pipe[k][0] = incoming;
                if (in_br) stall_left[k] = 0;
                else if (stall_left[k] > 0) stall_left[k]--;
                else if (m_loaduse[k]) stall_left[k] = n_stalls[k] - 1;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] dst, input logic rw,
                         input logic mr, input logic br, input logic hd);
        in_rs = rs; in_rt = rt; in_urs = urs; in_urt = urt; in_dst = dst;
        in_rw = rw; in_mr = mr; in_br = br; in_hold = hd;
        if1.id_rs = rs; if1.id_rt = rt; if1.id_use_rs = urs; if1.id_use_rt = urt;
        if1.id_dst = dst; if1.id_reg_write = rw; if1.id_mem_read = mr;
        if1.ex_branch_tk = br; if1.hold = hd;
        #1;
        model_eval();
    endtask

    task automatic nop();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic flush_pipe();
        repeat (4) begin nop(); tick(); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        nop(); tick(); tick();
        rst = 1'b0;
        nop();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (o_a[k] !== 2'd0) begin n_errors++; $display("FAIL reset_fwd_a[%0d]: got %0d want 0", k, o_a[k]); end
            n_checks++; if (o_b[k] !== 2'd0) begin n_errors++; $display("FAIL reset_fwd_b[%0d]: got %0d want 0", k, o_b[k]); end
            n_checks++; if (o_pc[k] !== 1'b1 || o_ifwe[k] !== 1'b1) begin n_errors++; $display("FAIL reset_we[%0d]: got pc=%b ifid=%b want 1 1", k, o_pc[k], o_ifwe[k]); end
            n_checks++; if (o_fl[k] !== 1'b0 || o_bub[k] !== 1'b0) begin n_errors++; $display("FAIL reset_flush[%0d]: got fl=%b bub=%b want 0 0", k, o_fl[k], o_bub[k]); end
            n_checks++; if (o_st[k] !== ST_RUN || o_cnt[k] !== 2'd0) begin n_errors++; $display("FAIL reset_fsm[%0d]: got st=%0d cnt=%0d want 0 0", k, o_st[k], o_cnt[k]); end
        end
    endtask

    task automatic test_fwd_ex();
        flush_pipe();
        drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);  // add $3,$1,$2
        tick();
        drive(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);  // sub $4,$3,$5
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (o_a[k] !== 2'd2) begin n_errors++; $display("FAIL fwd_ex_a[%0d]: got %0d want 2", k, o_a[k]); end
            n_checks++; if (o_b[k] !== 2'd0) begin n_errors++; $display("FAIL fwd_ex_b[%0d]: got %0d want 0", k, o_b[k]); end
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);  // hold freezes selects
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (o_a[k] !== 2'd2) begin n_errors++; $display("FAIL hold_sel_a[%0d]: got %0d want 2", k, o_a[k]); end
        end
    endtask

    task automatic test_fwd_mem();
        flush_pipe();
        drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);  // add $3
        tick(); nop(); tick();
        drive(5'd0, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);  // or $6,$0,$3
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (o_a[k] !== 2'd0 || o_b[k] !== 2'd1) begin n_errors++; $display("FAIL fwd_mem[%0d]: got a=%0d b=%0d want 0 1", k, o_a[k], o_b[k]); end
        end
        flush_pipe();
        drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);  // add $0
        tick(); nop(); tick();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);  // or $6,$0,$0
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (o_a[k] !== 2'd0 || o_b[k] !== 2'd0) begin n_errors++; $display("FAIL fwd_zero[%0d]: got a=%0d b=%0d want 0 0", k, o_a[k], o_b[k]); end
        end
    endtask

    task automatic test_newest_wins();
        flush_pipe();
        drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);  // add $3
        tick();
        drive(5'd4, 5'd5, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);  // add $3 again
        tick();
        drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);  // consumer
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (o_a[k] !== 2'd2) begin n_errors++; $display("FAIL newest_alu[%0d]: got %0d want 2", k, o_a[k]); end
        end
        flush_pipe();
        drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);  // add $3
        tick();
        drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);  // lw $3,0($1)
        tick();
        drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);  // consumer of $3
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (o_pc[k] !== 1'b0 || o_bub[k] !== 1'b1) begin n_errors++; $display("FAIL newest_stall[%0d]: got pc=%b bub=%b want 0 1", k, o_pc[k], o_bub[k]); end
        end
        tick();
        drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (o_a[0] !== 2'd1 || o_b[0] !== 2'd1) begin n_errors++; $display("FAIL newest_load: got a=%0d b=%0d want 1 1", o_a[0], o_b[0]); end
    endtask

    task automatic test_load_use();
        flush_pipe();
        drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);  // lw $2,0($1)
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (o_pc[k] !== 1'b1) begin n_errors++; $display("FAIL lu_pre[%0d]: got pc=%b want 1", k, o_pc[k]); end
        end
        tick();
        drive(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);  // add $4,$2,$2
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (o_pc[k] !== 1'b0 || o_ifwe[k] !== 1'b0 || o_bub[k] !== 1'b1 || o_fl[k] !== 1'b0)
                begin n_errors++; $display("FAIL lu_stall1[%0d]: got pc=%b ifid=%b bub=%b fl=%b want 0 0 1 0", k, o_pc[k], o_ifwe[k], o_bub[k], o_fl[k]); end
        end
        tick();
        drive(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (o_pc[0] !== 1'b1 || o_bub[0] !== 1'b0) begin n_errors++; $display("FAIL lu1_release: got pc=%b bub=%b want 1 0", o_pc[0], o_bub[0]); end
        n_checks++; if (o_pc[1] !== 1'b0 || o_bub[1] !== 1'b1 || o_st[1] !== ST_STALL) begin n_errors++; $display("FAIL lu3_stall2: got pc=%b bub=%b st=%0d want 0 1 1", o_pc[1], o_bub[1], o_st[1]); end
        tick();
        n_checks++; if (o_a[0] !== 2'd1 || o_b[0] !== 2'd1) begin n_errors++; $display("FAIL lu1_sel: got a=%0d b=%0d want 1 1", o_a[0], o_b[0]); end
        drive(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (o_pc[1] !== 1'b0 || o_bub[1] !== 1'b1) begin n_errors++; $display("FAIL lu3_stall3: got pc=%b bub=%b want 0 1", o_pc[1], o_bub[1]); end
        tick();
        drive(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (o_pc[1] !== 1'b1 || o_bub[1] !== 1'b0 || o_st[1] !== ST_RUN) begin n_errors++; $display("FAIL lu3_release: got pc=%b bub=%b st=%0d want 1 0 0", o_pc[1], o_bub[1], o_st[1]); end
        tick();
        n_checks++; if (o_a[1] !== 2'd0 || o_b[1] !== 2'd0) begin n_errors++; $display("FAIL lu3_sel: got a=%0d b=%0d want 0 0", o_a[1], o_b[1]); end
    endtask

    task automatic test_branch_override();
        flush_pipe();
        drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);  // lw $2
        tick();
        drive(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);  // load-use + taken branch
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (o_fl[k] !== 1'b1 || o_bub[k] !== 1'b1 || o_pc[k] !== 1'b1)
                begin n_errors++; $display("FAIL br_override[%0d]: got fl=%b bub=%b pc=%b want 1 1 1", k, o_fl[k], o_bub[k], o_pc[k]); end
        end
        tick();
        nop();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (o_pc[k] !== 1'b1 || o_bub[k] !== 1'b0 || o_st[k] !== ST_RUN || o_cnt[k] !== 2'd0)
                begin n_errors++; $display("FAIL br_after[%0d]: got pc=%b bub=%b st=%0d cnt=%0d want 1 0 0 0", k, o_pc[k], o_bub[k], o_st[k], o_cnt[k]); end
        end
    endtask

    task automatic test_hold_mid_stall();
        flush_pipe();
        drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        repeat (4) begin
            drive(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);  // hold beats branch too
            for (int k = 0; k < 2; k++) begin
                n_checks++; if (o_pc[k] !== 1'b0 || o_ifwe[k] !== 1'b0 || o_bub[k] !== 1'b0 || o_fl[k] !== 1'b0)
                    begin n_errors++; $display("FAIL hold_ctrl[%0d]: got pc=%b ifid=%b bub=%b fl=%b want 0 0 0 0", k, o_pc[k], o_ifwe[k], o_bub[k], o_fl[k]); end
            end
            n_checks++; if (o_cnt[1] !== 2'd2 || o_st[1] !== ST_STALL) begin n_errors++; $display("FAIL hold_frozen: got cnt=%0d st=%0d want 2 1", o_cnt[1], o_st[1]); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++; if (o_bub[1] !== (i < 2) || o_pc[1] !== (i >= 2))
                begin n_errors++; $display("FAIL hold_resume%0d: got bub=%b pc=%b want %b %b", i, o_bub[1], o_pc[1], i < 2, i >= 2); end
            tick();
        end
    endtask

    task automatic test_rst_mid_stall();
        flush_pipe();
        drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (o_st[1] !== ST_STALL) begin n_errors++; $display("FAIL rst_pre_stall: got st=%0d want 1", o_st[1]); end
        rst = 1'b1;
        drive(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        nop();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (o_pc[k] !== 1'b1 || o_ifwe[k] !== 1'b1 || o_fl[k] !== 1'b0 || o_bub[k] !== 1'b0)
                begin n_errors++; $display("FAIL rst_ctrl[%0d]: got pc=%b ifid=%b fl=%b bub=%b want 1 1 0 0", k, o_pc[k], o_ifwe[k], o_fl[k], o_bub[k]); end
            n_checks++; if (o_a[k] !== 2'd0 || o_b[k] !== 2'd0 || o_st[k] !== ST_RUN || o_cnt[k] !== 2'd0)
                begin n_errors++; $display("FAIL rst_state[%0d]: got a=%0d b=%0d st=%0d cnt=%0d want 0 0 0 0", k, o_a[k], o_b[k], o_st[k], o_cnt[k]); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            for (int k = 0; k < 2; k++) begin
                n_checks++; if (o_pc[k] !== m_pc[k] || o_ifwe[k] !== m_ifwe[k] || o_fl[k] !== m_fl[k] || o_bub[k] !== m_bub[k])
                    begin n_errors++; $display("FAIL rand_ctrl[%0d] cyc %0d: got pc=%b ifid=%b fl=%b bub=%b want %b %b %b %b", k, c, o_pc[k], o_ifwe[k], o_fl[k], o_bub[k], m_pc[k], m_ifwe[k], m_fl[k], m_bub[k]); end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++; if (o_a[k] !== m_a[k] || o_b[k] !== m_b[k])
                    begin n_errors++; $display("FAIL rand_sel[%0d] cyc %0d: got a=%0d b=%0d want %0d %0d", k, c, o_a[k], o_b[k], m_a[k], m_b[k]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_fwd_ex();
        test_fwd_mem();
        test_newest_wins();
        test_load_use();
        test_branch_override();
        test_hold_mid_stall();
        test_rst_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
